// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared widths and FSM encoding for the register file access sequencer
package rf_pkg;

    localparam int RF_AW = 3;
    localparam int RF_DW = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_CAPT  = 3'd3,
        ST_RESP  = 3'd4
    } rf_state_t;

endpackage

// File: rtl/rf_access_seq.sv
// rtl/rf_access_seq.sv - serializes one write/read request into register file cycles and returns both operands
module rf_access_seq
    import rf_pkg::*;
#(
    parameter int AW = RF_AW,
    parameter int DW = RF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wr_en,
    input  logic [AW-1:0] req_wr_addr,
    input  logic [DW-1:0] req_wr_data,
    input  logic          req_rd_en,
    input  logic [AW-1:0] req_rd_a,
    input  logic [AW-1:0] req_rd_b,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data_a,
    output logic [DW-1:0] rsp_data_b,
    output logic [AW-1:0] rf_address_a,
    output logic [AW-1:0] rf_address_b,
    output logic          rf_write_enable,
    output logic [DW-1:0] rf_write_data,
    input  logic [DW-1:0] rf_data_a,
    input  logic [DW-1:0] rf_data_b
);

    rf_state_t     state;
    logic          wr_en_q;
    logic [AW-1:0] wr_addr_q;
    logic [DW-1:0] wr_data_q;
    logic          rd_en_q;
    logic [AW-1:0] rd_a_q;
    logic [AW-1:0] rd_b_q;
    logic [DW-1:0] rsp_a_q;
    logic [DW-1:0] rsp_b_q;

    // Sequencer FSM: latch the request, issue write then read, capture the registered read data, hold response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_en_q   <= 1'b0;
            rd_a_q    <= '0;
            rd_b_q    <= '0;
            rsp_a_q   <= '0;
            rsp_b_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        wr_en_q   <= req_wr_en;
                        wr_addr_q <= req_wr_addr;
                        wr_data_q <= req_wr_data;
                        rd_en_q   <= req_rd_en;
                        rd_a_q    <= req_rd_a;
                        rd_b_q    <= req_rd_b;
                        if (req_wr_en) begin
                            state <= ST_WRITE;
                        end else if (req_rd_en) begin
                            state <= ST_READ;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_WRITE: begin
                    state <= rd_en_q ? ST_READ : ST_IDLE;
                end
                ST_READ: begin
                    state <= ST_CAPT;
                end
                ST_CAPT: begin
                    // Register file read data is valid one cycle after the READ address cycle
                    rsp_a_q <= rf_data_a;
                    rsp_b_q <= rf_data_b;
                    state   <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Register file and handshake outputs decoded from state and latched fields only, forced quiet while in reset
    always_comb begin
        req_ready       = 1'b0;
        rsp_valid       = 1'b0;
        rf_address_a    = '0;
        rf_address_b    = '0;
        rf_write_enable = 1'b0;
        rf_write_data   = '0;
        if (rst_n) begin
            case (state)
                ST_IDLE: begin
                    req_ready = 1'b1;
                end
                ST_WRITE: begin
                    rf_address_a    = wr_addr_q;
                    rf_write_data   = wr_data_q;
                    rf_write_enable = 1'b1;
                end
                ST_READ: begin
                    rf_address_a = rd_a_q;
                    rf_address_b = rd_b_q;
                end
                ST_RESP: begin
                    rsp_valid = 1'b1;
                end
                default: begin
                    req_ready = 1'b0;
                end
            endcase
        end
    end

    assign rsp_data_a = rsp_a_q;
    assign rsp_data_b = rsp_b_q;

endmodule
